ghr: RTL and testbench

Global history register for the branch predictor. It records the outcomes of the last two resolved conditional branches and drives `LocalSrc`, which selects one of four local 2-bit predictor tables. It sits beside the Execute stage: it updates when a conditional branch resolves and holds its value otherwise.

---
 rtl/ghr_pkg.sv | 20 ++
 rtl/ghr.sv | 49 ++++
 tb/tb_ghr.sv | 116 +++++++++++
 3 files changed

// File: rtl/ghr_pkg.sv
// ============================================================================
// ghr_pkg : shared branch-predictor constants (history encodings, defaults)
// Rev 1.0
// ============================================================================
`default_nettype none

package ghr_pkg;

  // Two-outcome history encodings: older outcome on the left, U = untaken, T = taken.
  localparam logic [1:0] UU = 2'b00;
  localparam logic [1:0] UT = 2'b01;
  localparam logic [1:0] TU = 2'b10;
  localparam logic [1:0] TT = 2'b11;

  localparam int unsigned GHR_HIST_BITS_DEF = 2;
  localparam logic [1:0]  GHR_RESET_DEF     = UT;

endpackage : ghr_pkg

`default_nettype wire

// File: rtl/ghr.sv
// ============================================================================
// ghr : global history of the last resolved conditional-branch outcomes
// Rev 1.0
// ============================================================================
`default_nettype none

module ghr
  import ghr_pkg::*;
#(
  parameter int unsigned                HIST_BITS = GHR_HIST_BITS_DEF,
  parameter logic [HIST_BITS-1:0]       RESET_VAL = HIST_BITS'(GHR_RESET_DEF)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 BranchOpEb0,
  input  logic                 PCSrcResE,
  output logic [HIST_BITS-1:0] LocalSrc
);

  logic [HIST_BITS-1:0] hist_q;
  logic [HIST_BITS-1:0] hist_d;

  // Newest outcome enters at the LSB; the oldest bit falls off the top.
  always_comb begin
    hist_d = hist_q;
    if (BranchOpEb0) begin
      hist_d = {hist_q[HIST_BITS-2:0], PCSrcResE};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= RESET_VAL;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign LocalSrc = hist_q;

`ifndef SYNTHESIS
  a_hold_when_idle : assert property (
    @(posedge clk) disable iff (reset) !BranchOpEb0 |=> $stable(LocalSrc)
  );
`endif

endmodule : ghr

`default_nettype wire

// File: tb/tb_ghr.sv
// ============================================================================
// tb_ghr : directed self-checking bench for the global history register
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ghr;

  logic       clk;
  logic       reset;
  logic       BranchOpEb0;
  logic       PCSrcResE;
  logic [1:0] LocalSrc;

  int checks = 0;
  int errors = 0;

  ghr dut (
    .clk         (clk),
    .reset       (reset),
    .BranchOpEb0 (BranchOpEb0),
    .PCSrcResE   (PCSrcResE),
    .LocalSrc    (LocalSrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] exp);
    checks++;
    assert (LocalSrc === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, LocalSrc, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then settle 1 time unit before sampling.
  task automatic cyc(input logic en, input logic pc);
    BranchOpEb0 = en;
    PCSrcResE   = pc;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_h;
  logic [1:0] t3_exp [4];
  logic       pc_v;

  initial begin
    t3_exp[0] = 2'b10; t3_exp[1] = 2'b00; t3_exp[2] = 2'b00; t3_exp[3] = 2'b00;

    // 1: reset, then hold with enable low
    reset = 1'b1; BranchOpEb0 = 1'b0; PCSrcResE = 1'b0;
    #1;
    chk("reset_async", 2'b01);
    @(posedge clk); #1;
    chk("reset_held", 2'b01);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, i[0]);
      chk("post_reset_idle", 2'b01);
    end

    // 2: taken x4 from UT
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1);
      chk("taken_run", 2'b11);
    end

    // 3: not taken x4 from TT
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0);
      chk("untaken_run", t3_exp[i]);
    end

    // 4: outcome toggling every 4 cycles from UT
    #2; reset = 1'b1; #1; reset = 1'b0;
    chk("midcycle_reset_pulse", 2'b01);
    exp_h = 2'b01;
    for (int i = 0; i < 32; i++) begin
      pc_v  = ((i / 4) % 2) == 0;
      cyc(1'b1, pc_v);
      exp_h = {exp_h[0], pc_v};
      chk("toggle_shift", exp_h);
    end

    // 5: enable low, outcome toggling, value frozen
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, ((i / 4) % 2) == 0);
      chk("idle_hold", exp_h);
    end

    // 6: reach TU, then async reset between edges with enable high
    cyc(1'b1, 1'b1);
    chk("pre6_taken", 2'b01);
    cyc(1'b1, 1'b0);
    chk("pre6_tu", 2'b10);
    BranchOpEb0 = 1'b1; PCSrcResE = 1'b1;
    #2; reset = 1'b1; #1;
    chk("async_reset_midcycle", 2'b01);
    @(posedge clk); #1;
    chk("reset_beats_enable", 2'b01);
    reset = 1'b0;
    cyc(1'b1, 1'b1);
    chk("first_after_release", 2'b11);
    cyc(1'b1, 1'b0);
    chk("second_after_release", 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ghr

`default_nettype wire
